dmem_responder: RTL and testbench

- Data-memory responder at the far end of the core's load/store request channel.
- Accepts one word-aligned load or store request through a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or a write acknowledgement on a separate valid/ready response channel.
- Gives the pipelined core a realistic, stallable data-memory model to integrate against.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 109 ++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - load/store request and response channel bundle
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with wait states
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_wstrb;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]   acc_wstrb;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          mem_we;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));

  // With no wait states the access happens on the acceptance edge, so it
  // must use the live request rather than the holding registers.
  assign acc_we    = (state == IDLE) ? bus.req_we    : hold_we;
  assign acc_addr  = (state == IDLE) ? bus.req_addr  : hold_addr;
  assign acc_wdata = (state == IDLE) ? bus.req_wdata : hold_wdata;
  assign acc_wstrb = (state == IDLE) ? bus.req_wstrb : hold_wstrb;

  assign acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
  assign acc_idx = acc_addr[AW+1:2];
  assign mem_we  = enter_resp && acc_we && !acc_err && rst;

  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      hold_we       <= 1'b0;
      hold_addr     <= 32'd0;
      hold_wdata    <= 32'd0;
      hold_wstrb    <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_we    <= bus.req_we;
            hold_addr  <= bus.req_addr;
            hold_wdata <= bus.req_wdata;
            hold_wstrb <= bus.req_wstrb;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= acc_err;
        bus.rsp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_wstrb[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder
module tb_dmem_responder;

  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy2, busy0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if m2 ();
  dmem_responder_if m0 ();

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .rst(rst), .bus(m2.slave), .busy(busy2)
  );

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(m0.slave), .busy(busy0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    int lat;
    @(negedge clk);
    m2.req_valid = 1'b1;
    m2.req_we    = v.we;
    m2.req_addr  = v.addr;
    m2.req_wdata = v.wdata;
    m2.req_wstrb = v.wstrb;
    m2.rsp_ready = (v.hold == 0);
    w = 0;
    while (!m2.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d req_ready", idx), 32'(m2.req_ready), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) m2.req_valid = 1'b0;
    end while (!m2.rsp_valid && lat < 40);
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(W2 + 1));
    check($sformatf("v%0d rdata", idx), m2.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d err", idx), 32'(m2.rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d ready_in_resp", idx), 32'(m2.req_ready), 32'd0);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check($sformatf("v%0d bp valid", idx), 32'(m2.rsp_valid), 32'd1);
      check($sformatf("v%0d bp rdata", idx), m2.rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d bp err", idx), 32'(m2.rsp_err), 32'(v.exp_err));
      check($sformatf("v%0d bp ready", idx), 32'(m2.req_ready), 32'd0);
    end
    m2.rsp_ready = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d valid_drop", idx), 32'(m2.rsp_valid), 32'd0);
    check($sformatf("v%0d idle_ready", idx), 32'(m2.req_ready), 32'd1);
    check($sformatf("v%0d idle_busy", idx), 32'(busy2), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 0, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 0, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 32'hDE22_BE44, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 0, 32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         4'h0, 0, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'hF, 0, 32'h0000_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 0, 32'h1111_1111, 1'b0};
    vecs[15] = '{1'b1, 32'h0000_0011, 32'h7777_7777, 4'hF, 3, 32'h0000_0000, 1'b1};

    m2.req_valid = 1'b0; m2.req_we = 1'b0; m2.req_addr = '0; m2.req_wdata = '0;
    m2.req_wstrb = '0;   m2.rsp_ready = 1'b1;
    m0.req_valid = 1'b0; m0.req_we = 1'b0; m0.req_addr = '0; m0.req_wdata = '0;
    m0.req_wstrb = '0;   m0.rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(m2.req_ready), 32'd1);
    check("rst rsp_valid", 32'(m2.rsp_valid), 32'd0);
    check("rst rsp_rdata", m2.rsp_rdata, 32'd0);
    check("rst rsp_err", 32'(m2.rsp_err), 32'd0);
    check("rst busy", 32'(busy2), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset during WAIT of a store: no response, word 8 keeps its old value.
    @(negedge clk);
    m2.req_valid = 1'b1; m2.req_we = 1'b1; m2.req_addr = 32'h20;
    m2.req_wdata = 32'h9999_9999; m2.req_wstrb = 4'hF; m2.rsp_ready = 1'b1;
    @(negedge clk);
    m2.req_valid = 1'b0;
    check("mid busy_before_rst", 32'(busy2), 32'd1);
    rst = 1'b0;
    #1;
    check("mid busy_in_rst", 32'(busy2), 32'd0);
    check("mid valid_in_rst", 32'(m2.rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= m2.rsp_valid;
    end
    check("mid no_response", 32'(seen), 32'd0);
    run_vec(vecs[14], 14);

    // Zero wait states, requests held back-to-back: one response every 2 cycles.
    @(negedge clk);
    m0.rsp_ready = 1'b1; m0.req_valid = 1'b1; m0.req_we = 1'b1;
    m0.req_addr = 32'h4; m0.req_wdata = 32'h0BAD_CAFE; m0.req_wstrb = 4'hF;
    check("w0 ready_start", 32'(m0.req_ready), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("w0 c%0d rsp_valid", i), 32'(m0.rsp_valid), 32'(i % 2));
      check($sformatf("w0 c%0d req_ready", i), 32'(m0.req_ready), 32'((i + 1) % 2));
      if (i % 2 == 1) check($sformatf("w0 c%0d rdata", i), m0.rsp_rdata, 32'd0);
    end
    m0.req_we = 1'b0;
    @(negedge clk);
    check("w0 load valid", 32'(m0.rsp_valid), 32'd1);
    check("w0 load rdata", m0.rsp_rdata, 32'h0BAD_CAFE);
    check("w0 load err", 32'(m0.rsp_err), 32'd0);
    m0.req_valid = 1'b0;
    @(negedge clk);
    check("w0 end valid", 32'(m0.rsp_valid), 32'd0);
    check("w0 end busy", 32'(busy0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
